// File: rtl/rr_burst_scheduler_if.sv
// Handshake bundle between requesters and the round-robin burst scheduler.
// Latency: n/a (wires only).
// Backpressure: none here; the scheduler holds a grant until the burst ends or is preempted.
// Signals: req_in/beat_in/last_in are driven by the requester side (master);
//          grant_out/grant_id/grant_valid/beat_cnt/preempt_out by the scheduler (slave).
interface rr_burst_scheduler_if #(
  parameter int NumReq  = 3,
  parameter int MaxHold = 8
);
  localparam int IdW  = $clog2(NumReq);
  localparam int CntW = $clog2(MaxHold + 1);

  logic [NumReq-1:0] req_in;       // per-requester request level
  logic              beat_in;      // one beat accepted from the granted requester
  logic              last_in;      // qualifies beat_in: final beat of the burst
  logic [NumReq-1:0] grant_out;    // registered one-hot grant, zero when idle
  logic [IdW-1:0]    grant_id;     // index of granted requester while grant_valid
  logic              grant_valid;  // grant_out != 0
  logic [CntW-1:0]   beat_cnt;     // beats accepted in the current grant
  logic              preempt_out;  // one-cycle pulse after a hold-limit release

  modport master (
    output req_in, beat_in, last_in,
    input  grant_out, grant_id, grant_valid, beat_cnt, preempt_out
  );

  modport slave (
    input  req_in, beat_in, last_in,
    output grant_out, grant_id, grant_valid, beat_cnt, preempt_out
  );
endinterface

// File: rtl/rr_burst_scheduler.sv
// Round-robin burst scheduler: grants one requester at a time and holds it for a whole burst.
// Latency: request seen at edge N -> grant visible in cycle N+1; one dead cycle between grants.
// Backpressure: other requests wait while BUSY; a grant ends on last beat, MaxHold beats, or abandon.
// Ports: clk, rstN (synchronous, active-low), sched (slave side of rr_burst_scheduler_if).
module rr_burst_scheduler #(
  parameter int NumReq  = 3,
  parameter int MaxHold = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  rr_burst_scheduler_if.slave  sched
);
  localparam int IdW  = $clog2(NumReq);
  localparam int CntW = $clog2(MaxHold + 1);

  localparam logic [IdW-1:0]  PtrRst   = IdW'(NumReq - 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(MaxHold - 1);
  localparam logic [CntW-1:0] HoldMax  = CntW'(MaxHold);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [NumReq-1:0] r_grant, w_grant_nxt;
  logic [IdW-1:0]    r_id,    w_id_nxt;
  logic [IdW-1:0]    r_ptr,   w_ptr_nxt;
  logic [CntW-1:0]   r_cnt,   w_cnt_nxt;
  logic              r_preempt, w_preempt_nxt;

  logic [IdW-1:0]    w_pick;
  logic              w_pick_vld;

  // Scan ptr+1, ptr+2, ... (mod NumReq); the first requester found wins, so the
  // most recently released requester (ptr) is always considered last.
  always_comb begin
    int idx;
    w_pick     = '0;
    w_pick_vld = 1'b0;
    idx        = 0;
    for (int i = 1; i <= NumReq; i++) begin
      idx = (int'(r_ptr) + i) % NumReq;
      if (!w_pick_vld && sched.req_in[idx]) begin
        w_pick     = IdW'(idx);
        w_pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    logic w_release;
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_id_nxt      = r_id;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_preempt_nxt = 1'b0;
    w_release     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // beat_in/last_in carry no meaning without a grant
        if (w_pick_vld) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = NumReq'(1) << w_pick;
          w_id_nxt    = w_pick;
          w_cnt_nxt   = '0;
        end
      end

      ST_BUSY: begin
        if (sched.beat_in && sched.last_in) begin
          // normal end of burst; wins over the hold limit on the same beat
          w_release = 1'b1;
        end else if (sched.beat_in && (r_cnt == HoldLast)) begin
          // this beat is the MaxHold-th one of the grant
          w_release     = 1'b1;
          w_preempt_nxt = 1'b1;
        end else if (!sched.req_in[r_id] && !sched.beat_in) begin
          // requester walked away mid-grant
          w_release = 1'b1;
        end else if (sched.beat_in && (r_cnt != HoldMax)) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end

        if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = r_id;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_id      <= '0;
      r_ptr     <= PtrRst;
      r_cnt     <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_id      <= w_id_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  assign sched.grant_out   = r_grant;
  assign sched.grant_id    = r_id;
  assign sched.grant_valid = |r_grant;
  assign sched.beat_cnt    = r_cnt;
  assign sched.preempt_out = r_preempt;

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Bench for rr_burst_scheduler: directed scenarios then randomized traffic vs a reference model.
// Inputs change on the falling edge; outputs are compared on the falling edge after each rising edge.
module tb_rr_burst_scheduler;
  localparam int N     = 3;
  localparam int MH    = 8;
  // worst wait: two other full grants plus three dead cycles (its own release, and after each other grant)
  localparam int BOUND = (N - 1) * (MH + 1) + 1;

  logic clk;
  logic rstN;

  rr_burst_scheduler_if #(.NumReq(N), .MaxHold(MH)) sif ();

  rr_burst_scheduler #(.NumReq(N), .MaxHold(MH)) u_dut (
    .clk   (clk),
    .rstN  (rstN),
    .sched (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which requester holds the grant, how many beats it has had,
  // and who was released last (lowest priority next time).
  bit m_busy;
  bit m_pre;
  int m_g;
  int m_ptr;
  int m_cnt;

  bit starve_on;
  int wait_cnt [N];

  // Distance of requester r from the top-priority slot (the one after the last released).
  function automatic int prio_dist(input int r, input int last_rel);
    return (r - last_rel - 1 + 2 * N) % N;
  endfunction

  task automatic model_release(input bit pre);
    m_busy = 1'b0;
    m_ptr  = m_g;
    m_cnt  = 0;
    m_pre  = pre;
  endtask

  task automatic model_step();
    logic [N-1:0] req;
    int best;
    req  = sif.req_in;
    best = -1;
    if (!rstN) begin
      m_busy = 1'b0; m_g = 0; m_ptr = N - 1; m_cnt = 0; m_pre = 1'b0;
    end else begin
      m_pre = 1'b0;
      if (!m_busy) begin
        for (int r = 0; r < N; r++)
          if (req[r] && (best < 0 || prio_dist(r, m_ptr) < prio_dist(best, m_ptr)))
            best = r;
        if (best >= 0) begin
          m_busy = 1'b1; m_g = best; m_cnt = 0;
        end
      end else if (sif.beat_in && sif.last_in) begin
        model_release(1'b0);
      end else if (sif.beat_in && (m_cnt + 1 == MH)) begin
        model_release(1'b1);
      end else if (!req[m_g] && !sif.beat_in) begin
        model_release(1'b0);
      end else if (sif.beat_in) begin
        m_cnt = (m_cnt + 1 > MH) ? MH : m_cnt + 1;
      end
    end
  endtask

  task automatic compare();
    logic [N-1:0] exp_grant;
    exp_grant = '0;
    if (m_busy) exp_grant[m_g] = 1'b1;
    check_eq("grant_out",   sif.grant_out, exp_grant);
    check_eq("grant_valid", sif.grant_valid, m_busy);
    if (m_busy) check_eq("grant_id", sif.grant_id, m_g);
    check_eq("beat_cnt",    sif.beat_cnt, m_cnt);
    check_eq("preempt_out", sif.preempt_out, m_pre);
    check_eq("onehot0",     $onehot0(sif.grant_out), 1);
    check_eq("valid_or",    sif.grant_valid, |sif.grant_out);
    check_eq("cnt_le_max",  (int'(sif.beat_cnt) <= MH), 1);
    if (starve_on) begin
      for (int r = 0; r < N; r++) begin
        if (sif.req_in[r] && !sif.grant_out[r]) wait_cnt[r]++;
        else wait_cnt[r] = 0;
        check_eq($sformatf("starve%0d", r), (wait_cnt[r] <= BOUND), 1);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input logic [N-1:0] req, input logic beat, input logic last);
    sif.req_in  = req;
    sif.beat_in = beat;
    sif.last_in = last;
  endtask

  initial begin
    logic [N-1:0] exp_rot [3];
    logic [N-1:0] req_v;
    bit served [N];
    n_checks  = 0;
    n_fail    = 0;
    starve_on = 1'b0;
    for (int r = 0; r < N; r++) begin wait_cnt[r] = 0; served[r] = 1'b0; end
    exp_rot[0] = 3'b010; exp_rot[1] = 3'b100; exp_rot[2] = 3'b001;

    // reset state
    rstN = 1'b0;
    drive(3'b000, 1'b0, 1'b0);
    tick(); tick();
    check_eq("rst_grant", sif.grant_out, 0);
    check_eq("rst_id",    sif.grant_id, 0);
    check_eq("rst_valid", sif.grant_valid, 0);
    check_eq("rst_cnt",   sif.beat_cnt, 0);
    check_eq("rst_pre",   sif.preempt_out, 0);

    // rotation with everyone requesting
    rstN = 1'b1;
    drive(3'b111, 1'b0, 1'b0); tick();
    check_eq("rot_first", sif.grant_out, 3'b001);
    for (int k = 0; k < 3; k++) begin
      drive(3'b111, 1'b1, 1'b1); tick();
      check_eq("rot_dead", sif.grant_out, 0);
      drive(3'b111, 1'b0, 1'b0); tick();
      check_eq("rot_next", sif.grant_out, exp_rot[k]);
    end
    drive(3'b111, 1'b1, 1'b1); tick();
    drive(3'b000, 1'b0, 1'b0); tick();

    // lone requester, three-beat burst, re-granted after one dead cycle
    drive(3'b001, 1'b0, 1'b0); tick();
    check_eq("lone_grant", sif.grant_out, 3'b001);
    drive(3'b001, 1'b1, 1'b0); tick();
    check_eq("lone_cnt1", sif.beat_cnt, 1);
    tick();
    check_eq("lone_cnt2", sif.beat_cnt, 2);
    drive(3'b001, 1'b1, 1'b1); tick();
    check_eq("lone_drop", sif.grant_out, 0);
    check_eq("lone_nopre", sif.preempt_out, 0);
    drive(3'b001, 1'b0, 1'b0); tick();
    check_eq("lone_regrant", sif.grant_out, 3'b001);
    drive(3'b001, 1'b1, 1'b1); tick();

    // abandonment: grant 010, drop its request, ptr must move to 1
    drive(3'b010, 1'b0, 1'b0); tick();
    check_eq("aband_grant", sif.grant_out, 3'b010);
    drive(3'b000, 1'b0, 1'b0); tick();
    check_eq("aband_drop", sif.grant_out, 0);
    check_eq("aband_nopre", sif.preempt_out, 0);
    drive(3'b011, 1'b0, 1'b0); tick();
    check_eq("aband_ptr", sif.grant_out, 3'b001);

    // hold-limit preemption from a fresh reset
    rstN = 1'b0; tick();
    rstN = 1'b1;
    drive(3'b011, 1'b1, 1'b0); tick();
    check_eq("pre_grant", sif.grant_out, 3'b001);
    check_eq("pre_cnt0",  sif.beat_cnt, 0);
    for (int k = 1; k < MH; k++) begin
      tick();
      check_eq("pre_cnt", sif.beat_cnt, k);
    end
    tick();
    check_eq("pre_pulse", sif.preempt_out, 1);
    check_eq("pre_drop",  sif.grant_out, 0);
    tick();
    check_eq("pre_next",  sif.grant_out, 3'b010);
    check_eq("pre_clear", sif.preempt_out, 0);

    // reset mid-burst
    for (int k = 0; k < 5; k++) tick();
    check_eq("mid_cnt5", sif.beat_cnt, 5);
    rstN = 1'b0; tick();
    check_eq("mid_grant", sif.grant_out, 0);
    check_eq("mid_cnt",   sif.beat_cnt, 0);
    check_eq("mid_valid", sif.grant_valid, 0);
    rstN = 1'b1;
    drive(3'b110, 1'b0, 1'b0); tick();
    check_eq("mid_after", sif.grant_out, 3'b010);

    // unconstrained random traffic with occasional resets
    for (int c = 0; c < 10000; c++) begin
      rstN = ($urandom_range(0, 199) != 0);
      drive(N'($urandom), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
      tick();
    end

    // well-behaved traffic: requests held until served, a beat every cycle
    rstN = 1'b0;
    drive(3'b000, 1'b0, 1'b0); tick();
    rstN = 1'b1;
    starve_on = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      req_v = sif.req_in;
      for (int r = 0; r < N; r++) begin
        if (sif.grant_out[r]) begin
          served[r] = 1'b1;
        end else if (req_v[r]) begin
          if (served[r]) begin
            served[r] = 1'b0;
            if ($urandom_range(0, 1) == 1) req_v[r] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          req_v[r] = 1'b1;
        end
      end
      drive(req_v, 1'b1, ($urandom_range(0, 3) == 0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
